crc_serial: RTL and testbench

//   Bit-serial CRC-8 generator built on an LFSR with fixed seed and tap mask.

---
 rtl/crc_serial.sv | 47 ++++
 tb/tb_crc_serial.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/crc_serial.sv
// crc_serial: bit-serial CRC-8 LFSR; absorbs DATA while Active, then shifts the CRC out LSB first with Valid
//   CLK/RST (async, active-high) | DATA, Active: serial message in | CRC, Valid: serial CRC out
module crc_serial #(
  parameter int                 DATA_WD = 8,
  parameter logic [DATA_WD-1:0] SEED    = 8'hD8,
  parameter logic [DATA_WD-1:0] TAPS    = 8'b0100_0100
) (
  input  logic CLK,
  input  logic RST,
  input  logic DATA,
  input  logic Active,
  output logic CRC,
  output logic Valid
);
  localparam int CW = $clog2(DATA_WD + 1);
  logic [DATA_WD-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pending_q, pending_d, crc_q, crc_d, valid_q, valid_d;
  logic               fb, shift;
  // the MSB stage always takes fb directly, so it is forced into the xor mask regardless of TAPS
  always_comb begin
    fb        = DATA ^ lfsr_q[0];
    shift     = !Active && pending_q;
    lfsr_d    = Active ? ((lfsr_q >> 1) ^ ({DATA_WD{fb}} & {1'b1, TAPS[DATA_WD-2:0]}))
              : shift  ? lfsr_q >> 1 : lfsr_q;
    cnt_d     = Active ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    pending_d = Active || (shift && cnt_q != CW'(DATA_WD - 1));
    crc_d     = shift && lfsr_q[0];
    valid_d   = shift;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      lfsr_q    <= SEED;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      crc_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      crc_q     <= crc_d;
      valid_q   <= valid_d;
    end
  assign CRC   = crc_q;
  assign Valid = valid_q;
endmodule

// File: tb/tb_crc_serial.sv
// tb_crc_serial: directed and randomised checks of the serial CRC-8 generator
module tb_crc_serial;
  logic CLK = 1'b0, RST = 1'b0, DATA = 1'b0, Active = 1'b0;
  logic CRC, Valid;
  int pass_cnt = 0, total = 0;

  crc_serial dut (.CLK(CLK), .RST(RST), .DATA(DATA), .Active(Active), .CRC(CRC), .Valid(Valid));

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ref_crc(input logic [7:0] b);
    logic [7:0] r;
    logic f;
    r = 8'hD8;
    for (int i = 0; i < 8; i++) begin
      f = b[i] ^ r[0];
      r = {f, r[7:1]} ^ (f ? 8'h44 : 8'h00);
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    Active = 1'b0;
    DATA   = 1'b0;
    RST    = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      DATA   = b[i];
      Active = 1'b1;
    end
    @(negedge CLK);
    Active = 1'b0;
    DATA   = 1'b0;
  endtask

  task automatic collect(output logic [7:0] crc, output int w);
    crc = 8'h00;
    w   = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (Valid) begin
        if (w < 8) crc[w] = CRC;
        w++;
      end
    end
  endtask

  task automatic test_reset();
    #2 RST = 1'b1;
    #1;
    total++;
    if (Valid !== 1'b0 || CRC !== 1'b0) $display("FAIL reset_out: Valid=%b CRC=%b want 0 0", Valid, CRC);
    else pass_cnt++;
    total++;
    if (dut.lfsr_q !== 8'hD8) $display("FAIL reset_lfsr: got %h want d8", dut.lfsr_q);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_vector();
    logic [7:0] crc;
    int w;
    do_reset();
    send_byte(8'h93);
    collect(crc, w);
    total++;
    if (crc !== 8'h78) $display("FAIL vec93_crc: got %h want 78", crc);
    else pass_cnt++;
    total++;
    if (w != 8) $display("FAIL vec93_width: got %0d want 8", w);
    else pass_cnt++;
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      total++;
      if (Valid !== 1'b0) $display("FAIL idle_valid: cycle %0d Valid=%b want 0", c, Valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0] b, crc;
    int w;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      do_reset();
      send_byte(b);
      collect(crc, w);
      total++;
      if (crc !== ref_crc(b)) $display("FAIL rand_crc: data %h got %h want %h", b, crc, ref_crc(b));
      else pass_cnt++;
      total++;
      if (w != 8) $display("FAIL rand_width: data %h got %0d want 8", b, w);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_output();
    logic [7:0] crc;
    int v, w;
    do_reset();
    send_byte(8'h93);
    v = 0;
    for (int c = 0; c < 12 && v < 4; c++) begin
      @(negedge CLK);
      if (Valid) v++;
    end
    total++;
    if (v != 4) $display("FAIL midrst_reach: saw %0d Valid cycles want 4", v);
    else pass_cnt++;
    #2 RST = 1'b1;
    #1;
    total++;
    if (Valid !== 1'b0 || CRC !== 1'b0) $display("FAIL midrst_async: Valid=%b CRC=%b want 0 0", Valid, CRC);
    else pass_cnt++;
    total++;
    if (dut.lfsr_q !== 8'hD8) $display("FAIL midrst_lfsr: got %h want d8", dut.lfsr_q);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    send_byte(8'h93);
    collect(crc, w);
    total++;
    if (crc !== 8'h78 || w != 8) $display("FAIL midrst_rerun: crc %h width %0d want 78 8", crc, w);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [2:0] bits;
    int v;
    do_reset();
    send_byte(8'h93);
    v = 0;
    bits = 3'b111;
    for (int c = 0; c < 12 && v < 3; c++) begin
      @(negedge CLK);
      if (Valid) begin
        bits[v] = CRC;
        v++;
      end
    end
    total++;
    if (v != 3 || bits !== 3'b000) $display("FAIL abort_prefix: %0d bits %b want 3 000", v, bits);
    else pass_cnt++;
    Active = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      total++;
      if (Valid !== 1'b0) $display("FAIL abort_valid: cycle %0d Valid=%b want 0", c, Valid);
      else pass_cnt++;
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_vector();
    test_idle();
    test_random();
    test_reset_mid_output();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
